// File: rtl/hpm_counter_bank_pkg.sv
// Shared definitions for the hardware performance-monitor counter bank:
// CSR address map and the event source numbering used by evtsel.
package hpm_counter_bank_pkg;

    localparam logic [6:0] HPM_CNT_BASE = 7'h00;
    localparam logic [6:0] HPM_SEL_BASE = 7'h20;
    localparam logic [6:0] HPM_INHIBIT  = 7'h40;
    localparam logic [6:0] HPM_OVF      = 7'h41;
    localparam logic [6:0] HPM_IRQEN    = 7'h42;

    // Selector value 0 never counts; event e is wired to event_inc_i slice e-1.
    typedef enum logic [4:0] {
        EV_NONE           = 5'd0,
        EV_COMMIT         = 5'd1,
        EV_ICACHE_MISS    = 5'd2,
        EV_DCACHE_MISS    = 5'd3,
        EV_ITLB_MISS      = 5'd4,
        EV_DTLB_MISS      = 5'd5,
        EV_BRANCH_MISPRED = 5'd6,
        EV_FETCH_STALL    = 5'd7,
        EV_SB_STALL       = 5'd8,
        EV_LOAD_COMMIT    = 5'd9,
        EV_STORE_COMMIT   = 5'd10,
        EV_BRANCH_COMMIT  = 5'd11,
        EV_CALL_COMMIT    = 5'd12,
        EV_RET_COMMIT     = 5'd13,
        EV_EXCEPTION      = 5'd14,
        EV_INTERRUPT      = 5'd15,
        EV_CYCLE          = 5'd16
    } hpm_event_e;

endpackage

// File: rtl/hpm_counter_slice.sv
// One programmable performance counter: event select, inhibit/freeze gating,
// CSR overwrite and a single-cycle overflow pulse on unsigned carry out.
module hpm_counter_slice #(
    parameter int NUM_EVENTS = 16,
    parameter int INC_W      = 2,
    parameter int CNT_WIDTH  = 64,
    parameter int SEL_W      = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [SEL_W-1:0]            sel,
    input  logic                        inhibit,
    input  logic                        freeze,
    input  logic                        we,
    input  logic [CNT_WIDTH-1:0]        wdata,
    input  logic [NUM_EVENTS*INC_W-1:0] events,
    output logic [CNT_WIDTH-1:0]        count,
    output logic                        ovf
);

    localparam int SUM_W = ((CNT_WIDTH > INC_W) ? CNT_WIDTH : INC_W) + 1;

    logic [INC_W-1:0] inc;
    logic             sel_hit;
    logic             active;
    logic [SUM_W-1:0] sum;

    // Out-of-range selectors match no slice, so they behave like "no event".
    always_comb begin
        inc     = '0;
        sel_hit = 1'b0;
        for (int e = 0; e < NUM_EVENTS; e++) begin
            if (sel == SEL_W'(e + 1)) begin
                inc     = events[e*INC_W +: INC_W];
                sel_hit = 1'b1;
            end
        end
    end

    assign active = sel_hit && !inhibit && !freeze;
    assign sum    = SUM_W'(count) + SUM_W'(inc);
    assign ovf    = active && !we && (|sum[SUM_W-1:CNT_WIDTH]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (we) begin
            count <= wdata;
        end else if (active) begin
            count <= sum[CNT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/hpm_counter_bank.sv
// Performance-monitor bank: CSR decode, per-counter slices, sticky W1C
// overflow status and the registered, maskable overflow interrupt.
module hpm_counter_bank
    import hpm_counter_bank_pkg::*;
#(
    parameter int NUM_COUNTERS = 8,
    parameter int NUM_EVENTS   = 16,
    parameter int INC_W        = 2,
    parameter int CNT_WIDTH    = 64,
    parameter int XLEN         = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        debug_mode_i,
    input  logic [6:0]                  addr_i,
    input  logic                        we_i,
    input  logic [XLEN-1:0]             wdata_i,
    output logic [XLEN-1:0]             rdata_o,
    output logic                        err_o,
    input  logic [NUM_EVENTS*INC_W-1:0] event_inc_i,
    output logic                        irq_o
);

    localparam int SEL_W = $clog2(NUM_EVENTS + 1);

    logic [4:0]              idx;
    logic                    idx_ok;
    logic                    is_cnt, is_sel, is_inh, is_ovf, is_irqen;
    logic [SEL_W-1:0]        evtsel [NUM_COUNTERS];
    logic [CNT_WIDTH-1:0]    cnt_val [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] inhibit;
    logic [NUM_COUNTERS-1:0] ovf_status;
    logic [NUM_COUNTERS-1:0] ovf_irq_en;
    logic [NUM_COUNTERS-1:0] ovf_pulse;

    assign idx      = addr_i[4:0];
    assign idx_ok   = (32'(idx) < NUM_COUNTERS);
    assign is_cnt   = (addr_i[6:5] == HPM_CNT_BASE[6:5]) && idx_ok;
    assign is_sel   = (addr_i[6:5] == HPM_SEL_BASE[6:5]) && idx_ok;
    assign is_inh   = (addr_i == HPM_INHIBIT);
    assign is_ovf   = (addr_i == HPM_OVF);
    assign is_irqen = (addr_i == HPM_IRQEN);
    assign err_o    = !(is_cnt || is_sel || is_inh || is_ovf || is_irqen);

    for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_slice
        hpm_counter_slice #(
            .NUM_EVENTS (NUM_EVENTS),
            .INC_W      (INC_W),
            .CNT_WIDTH  (CNT_WIDTH),
            .SEL_W      (SEL_W)
        ) u_slice (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .sel     (evtsel[g]),
            .inhibit (inhibit[g]),
            .freeze  (debug_mode_i),
            .we      (we_i && is_cnt && (idx == 5'(g))),
            .wdata   (wdata_i[CNT_WIDTH-1:0]),
            .events  (event_inc_i),
            .count   (cnt_val[g]),
            .ovf     (ovf_pulse[g])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                evtsel[i] <= '0;
            end
            inhibit    <= '0;
            ovf_irq_en <= '0;
        end else if (we_i) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                if (is_sel && (idx == 5'(i))) begin
                    evtsel[i] <= wdata_i[SEL_W-1:0];
                end
            end
            if (is_inh) begin
                inhibit <= wdata_i[NUM_COUNTERS-1:0];
            end
            if (is_irqen) begin
                ovf_irq_en <= wdata_i[NUM_COUNTERS-1:0];
            end
        end
    end

    // New overflow pulses are OR-ed in after the W1C mask so a same-cycle set is never lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_status <= '0;
            irq_o      <= 1'b0;
        end else begin
            if (we_i && is_ovf) begin
                ovf_status <= (ovf_status & ~wdata_i[NUM_COUNTERS-1:0]) | ovf_pulse;
            end else begin
                ovf_status <= ovf_status | ovf_pulse;
            end
            irq_o <= |(ovf_status & ovf_irq_en);
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (is_cnt && (idx == 5'(i))) begin
                rdata_o = XLEN'(cnt_val[i]);
            end
            if (is_sel && (idx == 5'(i))) begin
                rdata_o = XLEN'(evtsel[i]);
            end
        end
        if (is_inh) begin
            rdata_o = XLEN'(inhibit);
        end
        if (is_ovf) begin
            rdata_o = XLEN'(ovf_status);
        end
        if (is_irqen) begin
            rdata_o = XLEN'(ovf_irq_en);
        end
    end

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Bench for hpm_counter_bank: register-level reference model checked every
// negedge, plus directed scenarios with hand-computed literal expectations.
module tb_hpm_counter_bank;

    localparam logic [63:0] MAX64 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        rst_i;
    logic        debug_mode_i;
    logic [6:0]  addr_i;
    logic        we_i;
    logic [63:0] wdata_i;
    logic [63:0] rdata_o;
    logic        err_o;
    logic [31:0] event_inc_i;
    logic        irq_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: what the CSRs must hold after each edge.
    logic [63:0] m_cnt [8] = '{default: '0};
    logic [4:0]  m_sel [8] = '{default: '0};
    logic [7:0]  m_inh = '0;
    logic [7:0]  m_ovf = '0;
    logic [7:0]  m_en  = '0;
    logic        m_irq = 1'b0;

    logic [6:0]  scan [10] = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07, 7'h41, 7'h42};

    hpm_counter_bank dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .debug_mode_i (debug_mode_i),
        .addr_i       (addr_i),
        .we_i         (we_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .event_inc_i  (event_inc_i),
        .irq_o        (irq_o)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {err, data} the register map must return for address a
    function automatic logic [64:0] model_read(input logic [6:0] a);
        if (a < 7'h08)                     return {1'b0, m_cnt[a[2:0]]};
        if (a >= 7'h20 && a < 7'h28)       return {1'b0, 59'd0, m_sel[a[2:0]]};
        if (a == 7'h40)                    return {1'b0, 56'd0, m_inh};
        if (a == 7'h41)                    return {1'b0, 56'd0, m_ovf};
        if (a == 7'h42)                    return {1'b0, 56'd0, m_en};
        return {1'b1, 64'd0};
    endfunction

    // Reference model update
    always @(posedge clk or posedge rst_i) begin
        logic [64:0] sum;
        logic [63:0] n_cnt [8];
        logic [7:0]  pulses;
        if (rst_i) begin
            for (int i = 0; i < 8; i++) begin
                m_cnt[i] = '0;
                m_sel[i] = '0;
            end
            m_inh = '0;
            m_ovf = '0;
            m_en  = '0;
            m_irq = 1'b0;
        end else begin
            m_irq  = |(m_ovf & m_en);
            pulses = '0;
            for (int i = 0; i < 8; i++) begin
                n_cnt[i] = m_cnt[i];
                if (we_i && addr_i == 7'(i)) begin
                    n_cnt[i] = wdata_i;
                end else if (m_sel[i] >= 5'd1 && m_sel[i] <= 5'd16 && !m_inh[i] && !debug_mode_i) begin
                    sum = {1'b0, m_cnt[i]} + 65'(event_inc_i[(int'(m_sel[i]) - 1)*2 +: 2]);
                    n_cnt[i] = sum[63:0];
                    if (sum[64]) pulses[i] = 1'b1;
                end
            end
            for (int i = 0; i < 8; i++) begin
                m_cnt[i] = n_cnt[i];
                if (we_i && addr_i == 7'(32 + i)) m_sel[i] = wdata_i[4:0];
            end
            if (we_i && addr_i == 7'h40) m_inh = wdata_i[7:0];
            if (we_i && addr_i == 7'h42) m_en = wdata_i[7:0];
            if (we_i && addr_i == 7'h41) m_ovf = m_ovf & ~wdata_i[7:0];
            m_ovf = m_ovf | pulses;
        end
    end

    // Scoreboard compare every cycle, away from the active edge
    always @(negedge clk) begin
        logic [64:0] e;
        e = model_read(addr_i);
        check("rdata", rdata_o, e[63:0]);
        check("err", 64'(err_o), 64'(e[64]));
        check("irq", 64'(irq_o), 64'(m_irq));
    end

    // Driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [6:0] a, input logic [63:0] d);
        addr_i  = a;
        we_i    = 1'b1;
        wdata_i = d;
        cyc();
        we_i    = 1'b0;
        wdata_i = '0;
    endtask

    task automatic rd_chk(input string name, input logic [6:0] a, input logic [63:0] d, input logic e);
        addr_i = a;
        #1;
        check({name, "_data"}, rdata_o, d);
        check({name, "_err"}, 64'(err_o), 64'(e));
        cyc();
    endtask

    initial begin
        rst_i        = 1'b1;
        debug_mode_i = 1'b0;
        addr_i       = '0;
        we_i         = 1'b0;
        wdata_i      = '0;
        event_inc_i  = '0;
        #12;
        rst_i = 1'b0;
        cyc();

        // Reset values across the whole map
        for (int a = 0; a < 8; a++) rd_chk("rst_cnt", 7'(a), 64'd0, 1'b0);
        for (int a = 0; a < 8; a++) rd_chk("rst_sel", 7'(32 + a), 64'd0, 1'b0);
        for (int a = 0; a < 3; a++) rd_chk("rst_ctl", 7'(64 + a), 64'd0, 1'b0);
        check("rst_irq", 64'(irq_o), 64'd0);

        // Counting, inhibit and debug freeze
        wr(7'h20, 64'd1);
        event_inc_i = 32'h2;
        repeat (10) cyc();
        event_inc_i = '0;
        rd_chk("count20", 7'h00, 64'd20, 1'b0);
        wr(7'h40, 64'd1);
        event_inc_i = 32'h2;
        repeat (3) cyc();
        event_inc_i = '0;
        rd_chk("inhibit", 7'h00, 64'd20, 1'b0);
        wr(7'h40, 64'd0);
        debug_mode_i = 1'b1;
        event_inc_i  = 32'h2;
        repeat (3) cyc();
        event_inc_i  = '0;
        debug_mode_i = 1'b0;
        rd_chk("debug", 7'h00, 64'd20, 1'b0);

        // Overflow wrap and interrupt timing
        wr(7'h42, 64'd2);
        wr(7'h01, MAX64);
        wr(7'h21, 64'd1);
        event_inc_i = 32'h3;
        cyc();
        event_inc_i = '0;
        check("irq_not_yet", 64'(irq_o), 64'd0);
        rd_chk("wrap", 7'h01, 64'd2, 1'b0);
        check("irq_set", 64'(irq_o), 64'd1);
        rd_chk("ovf_bit1", 7'h41, 64'd2, 1'b0);
        wr(7'h41, 64'd2);
        check("irq_hold", 64'(irq_o), 64'd1);
        cyc();
        check("irq_drop", 64'(irq_o), 64'd0);
        rd_chk("ovf_clr", 7'h41, 64'd0, 1'b0);

        // Write beats a same-cycle overflowing increment
        wr(7'h00, MAX64);
        event_inc_i = 32'h3;
        wr(7'h00, 64'h55);
        event_inc_i = '0;
        rd_chk("wr_wins", 7'h00, 64'h55, 1'b0);
        rd_chk("wr_no_ovf", 7'h41, 64'd0, 1'b0);

        // W1C in the same cycle as a new overflow keeps the bit
        wr(7'h01, MAX64);
        wr(7'h21, 64'd2);
        event_inc_i = 32'hC;
        wr(7'h41, 64'd2);
        event_inc_i = '0;
        rd_chk("set_wins", 7'h41, 64'd2, 1'b0);
        rd_chk("wrap2", 7'h01, 64'd2, 1'b0);
        wr(7'h41, 64'hFF);

        // Unmapped addresses and out-of-range selector
        rd_chk("err_cnt8", 7'h08, 64'd0, 1'b1);
        rd_chk("err_43", 7'h43, 64'd0, 1'b1);
        rd_chk("err_sel8", 7'h28, 64'd0, 1'b1);
        rd_chk("err_7f", 7'h7F, 64'd0, 1'b1);
        wr(7'h08, 64'd123);
        wr(7'h43, 64'd5);
        wr(7'h28, 64'd3);
        rd_chk("ignored_wr", 7'h00, 64'h55, 1'b0);
        rd_chk("ignored_ctl", 7'h40, 64'd0, 1'b0);
        wr(7'h02, 64'd7);
        wr(7'h22, 64'd17);
        event_inc_i = 32'hFFFF_FFFF;
        repeat (3) cyc();
        event_inc_i = '0;
        rd_chk("sel17_hold", 7'h02, 64'd7, 1'b0);
        rd_chk("sel17_kept", 7'h22, 64'd17, 1'b0);
        rd_chk("sel_other", 7'h00, 64'h5E, 1'b0);

        // Mixed traffic: model-checked each cycle through the scanned address
        wr(7'h42, 64'hFF);
        wr(7'h40, 64'h10);
        wr(7'h03, 64'hFFFF_FFFF_FFFF_FFF0);
        wr(7'h23, 64'd4);
        wr(7'h24, 64'd16);
        wr(7'h25, 64'd9);
        wr(7'h27, 64'd1);
        for (int k = 0; k < 40; k++) begin
            event_inc_i  = $urandom;
            debug_mode_i = ($urandom_range(0, 7) == 0);
            addr_i       = scan[k % 10];
            cyc();
        end
        event_inc_i  = '0;
        debug_mode_i = 1'b0;

        // Asynchronous reset between edges
        addr_i      = 7'h00;
        event_inc_i = 32'h2;
        rst_i       = 1'b1;
        #1;
        check("async_cnt", rdata_o, 64'd0);
        check("async_irq", 64'(irq_o), 64'd0);
        cyc();
        check("rst_hold", rdata_o, 64'd0);
        rst_i       = 1'b0;
        event_inc_i = '0;
        cyc();
        rd_chk("post_rst_sel", 7'h20, 64'd0, 1'b0);
        rd_chk("post_rst_ovf", 7'h41, 64'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
